// File: rtl/interface_hcsr04_bcd.sv
// HC-SR04 ultrasonic front end: issues the trigger pulse, times the echo and
// converts its width to centimetres as a saturating 3-digit BCD value.
module interface_hcsr04_bcd #(
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int TIMEOUT_CICLOS = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  // One counter is shared by the trigger width, the echo wait and the echo
  // high time, so it must hold the larger of the two limits.
  localparam int CNT_MAX = (TIMEOUT_CICLOS > TRIGGER_CICLOS) ? TIMEOUT_CICLOS : TRIGGER_CICLOS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int MW      = (CICLOS_CM > 2) ? $clog2(CICLOS_CM) : 1;

  localparam logic [CW-1:0] TRIG_LAST  = CW'(TRIGGER_CICLOS - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0] HIGH_LIMIT = CW'(TIMEOUT_CICLOS);
  localparam logic [MW-1:0] MOD_LAST   = MW'(CICLOS_CM - 1);
  localparam logic [MW-1:0] MOD_HALF   = MW'(CICLOS_CM / 2 - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    TRIGGER     = 4'h2,
    ESPERA_ECHO = 4'h3,
    MEDE        = 4'h4,
    ARMAZENA    = 4'h5,
    FINAL       = 4'h6,
    TIMEOUT     = 4'h7
  } estado_t;

  estado_t     state;
  estado_t     next_state;
  logic        medir_prev;
  logic        medir_rise;
  logic        echo_meta;
  logic        echo_s;
  logic        conv_step;
  logic [CW-1:0] cnt;
  logic [MW-1:0] mod_cnt;
  logic [11:0] bcd;

  // BCD +1 with ripple carry across the three digits; sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  assign medir_rise = medir & ~medir_prev;

  // The first high echo cycle is seen while still waiting, so it is converted
  // there too; otherwise every echo would come out one clock short.
  assign conv_step = echo_s && ((state == ESPERA_ECHO) ||
                                ((state == MEDE) && (next_state == MEDE)));

  // Input conditioning: medir edge reference and 2-flop echo synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medir_prev <= 1'b0;
      echo_meta  <= 1'b0;
      echo_s     <= 1'b0;
    end else begin
      medir_prev <= medir;
      echo_meta  <= echo;
      echo_s     <= echo_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; on the last allowed echo cycle the timeout wins.
  always_comb begin
    next_state = state;
    case (state)
      INICIAL:     if (medir_rise) next_state = PREPARA; else next_state = INICIAL;
      PREPARA:     next_state = TRIGGER;
      TRIGGER:     if (cnt == TRIG_LAST) next_state = ESPERA_ECHO; else next_state = TRIGGER;
      ESPERA_ECHO: begin
        if (echo_s)                 next_state = MEDE;
        else if (cnt == WAIT_LAST)  next_state = TIMEOUT;
        else                        next_state = ESPERA_ECHO;
      end
      MEDE: begin
        if (cnt == HIGH_LIMIT)      next_state = TIMEOUT;
        else if (echo_s)            next_state = MEDE;
        else                        next_state = ARMAZENA;
      end
      ARMAZENA:    next_state = FINAL;
      FINAL:       next_state = INICIAL;
      TIMEOUT:     next_state = INICIAL;
      default:     next_state = INICIAL;
    endcase
  end

  // Shared cycle counter: trigger width, echo wait, then echo high time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (state)
        PREPARA:     cnt <= '0;
        TRIGGER:     cnt <= (next_state == ESPERA_ECHO) ? '0 : cnt + CW'(1);
        ESPERA_ECHO: cnt <= echo_s ? CW'(1) : cnt + CW'(1);
        MEDE:        cnt <= (next_state == MEDE) ? cnt + CW'(1) : cnt;
        default:     cnt <= cnt;
      endcase
    end
  end

  // Echo-to-centimetre conversion: BCD bumps at mid-period for rounding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mod_cnt <= '0;
      bcd     <= 12'h000;
    end else if (state == PREPARA) begin
      mod_cnt <= '0;
      bcd     <= 12'h000;
    end else if (conv_step) begin
      mod_cnt <= (mod_cnt == MOD_LAST) ? '0 : mod_cnt + MW'(1);
      if (mod_cnt == MOD_HALF) begin
        bcd <= bcd_inc(bcd);
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trigger   <= 1'b0;
      pronto    <= 1'b0;
      timeout   <= 1'b0;
      db_estado <= 4'h0;
      medida    <= 12'h000;
    end else begin
      trigger   <= (next_state == TRIGGER);
      pronto    <= (next_state == FINAL);
      timeout   <= (next_state == TIMEOUT);
      db_estado <= next_state;
      if (state == ARMAZENA) begin
        medida <= bcd;
      end
    end
  end

endmodule
